egress_frame_scheduler: RTL and testbench

Frame-granular round-robin scheduler that shares one egress RMII transmit path among ingress sources: the receive queues of the RMII ports and the virtual (module) ports. One instance sits in front of each egress transmitter inside `switch_core`. It grants the transmitter to exactly one requester for one whole frame, then enforces the Ethernet inter-frame gap before granting again. An optional watchdog frees the transmitter if a grant is held too long.

---
 rtl/switch_core_package.sv | 13 +
 rtl/round_robin_priority_encoder.sv | 32 +++
 rtl/egress_frame_scheduler.sv | 114 +++++++++++
 tb/tb_egress_frame_scheduler.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/switch_core_package.sv
// rtl/switch_core_package.sv - shared types and constants for the switch core egress path
package switch_core_package;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } egress_scheduler_state_t;

    localparam int RMII_BYTE_CYCLES               = 8;
    localparam int DEFAULT_INTER_FRAME_GAP_CYCLES = 12 * RMII_BYTE_CYCLES;

endpackage

// File: rtl/round_robin_priority_encoder.sv
// rtl/round_robin_priority_encoder.sv - picks the first eligible requester at or after the pointer
module round_robin_priority_encoder #(
    parameter int NUMBER_OF_REQUESTERS = 3,
    parameter int INDEX_WIDTH          = 2
) (
    input  logic [NUMBER_OF_REQUESTERS-1:0] request,
    input  logic [NUMBER_OF_REQUESTERS-1:0] request_enable,
    input  logic [INDEX_WIDTH-1:0]          pointer,
    output logic [INDEX_WIDTH-1:0]          winner,
    output logic                            any
);

    logic [NUMBER_OF_REQUESTERS-1:0] eligible;
    logic [INDEX_WIDTH-1:0]          candidate;

    assign eligible = request & request_enable;

    // Walk the candidates starting at the pointer, wrapping at the last requester; first hit wins
    always_comb begin
        winner    = '0;
        any       = 1'b0;
        candidate = pointer;
        for (int k = 0; k < NUMBER_OF_REQUESTERS; k++) begin
            if (!any && eligible[candidate]) begin
                winner = candidate;
                any    = 1'b1;
            end
            candidate = (candidate == INDEX_WIDTH'(NUMBER_OF_REQUESTERS - 1)) ? '0 : candidate + 1'b1;
        end
    end

endmodule

// File: rtl/egress_frame_scheduler.sv
// rtl/egress_frame_scheduler.sv - frame-granular round-robin egress arbiter with IFG; watchdog via EGRESS_SCHEDULER_WATCHDOG_EN
module egress_frame_scheduler
    import switch_core_package::*;
#(
    parameter int NUMBER_OF_REQUESTERS   = 3,
    parameter int INTER_FRAME_GAP_CYCLES = DEFAULT_INTER_FRAME_GAP_CYCLES,
    parameter int MAX_GRANT_CYCLES       = 1550 * RMII_BYTE_CYCLES,
    localparam int INDEX_WIDTH = (NUMBER_OF_REQUESTERS > 2) ? $clog2(NUMBER_OF_REQUESTERS) : 1
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic [NUMBER_OF_REQUESTERS-1:0] request,
    input  logic [NUMBER_OF_REQUESTERS-1:0] request_enable,
    input  logic                            frame_last,
    output logic [NUMBER_OF_REQUESTERS-1:0] grant,
    output logic                            grant_valid,
    output logic [INDEX_WIDTH-1:0]          grant_index,
    output logic                            grant_timeout
);

    localparam int GAP_WIDTH = $clog2(INTER_FRAME_GAP_CYCLES + 1);

    egress_scheduler_state_t state;
    logic [INDEX_WIDTH-1:0]  rr_pointer;
    logic [GAP_WIDTH-1:0]    gap_count;
    logic [INDEX_WIDTH-1:0]  winner;
    logic                    any;
    logic                    watchdog_expired;
    logic                    release_now;

    round_robin_priority_encoder #(
        .NUMBER_OF_REQUESTERS(NUMBER_OF_REQUESTERS),
        .INDEX_WIDTH         (INDEX_WIDTH)
    ) u_encoder (
        .request       (request),
        .request_enable(request_enable),
        .pointer       (rr_pointer),
        .winner        (winner),
        .any           (any)
    );

`ifdef EGRESS_SCHEDULER_WATCHDOG_EN
    localparam int WATCHDOG_WIDTH = $clog2(MAX_GRANT_CYCLES + 1);

    logic [WATCHDOG_WIDTH-1:0] watchdog_count;

    assign watchdog_expired = (state == GRANT) && (watchdog_count == WATCHDOG_WIDTH'(MAX_GRANT_CYCLES - 1));

    // Count cycles of the held grant; cleared outside GRANT so it restarts on every new grant.
    // frame_last in the expiry cycle takes precedence and suppresses the timeout pulse.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            watchdog_count <= '0;
            grant_timeout  <= 1'b0;
        end else begin
            grant_timeout <= watchdog_expired && !frame_last;
            if (state != GRANT) begin
                watchdog_count <= '0;
            end else if (!watchdog_expired) begin
                watchdog_count <= watchdog_count + 1'b1;
            end
        end
    end
`else
    assign watchdog_expired = 1'b0;
    assign grant_timeout    = 1'b0;
`endif

    assign release_now = frame_last || watchdog_expired;

    // Scheduler FSM: grant one frame, release on frame end (or watchdog), then sit out the gap
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_index <= '0;
            rr_pointer  <= '0;
            gap_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        grant       <= NUMBER_OF_REQUESTERS'(1) << winner;
                        grant_index <= winner;
                        grant_valid <= 1'b1;
                        state       <= GRANT;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        grant       <= '0;
                        grant_valid <= 1'b0;
                        gap_count   <= GAP_WIDTH'(INTER_FRAME_GAP_CYCLES - 1);
                        rr_pointer  <= (grant_index == INDEX_WIDTH'(NUMBER_OF_REQUESTERS - 1)) ?
                                       '0 : grant_index + 1'b1;
                        state       <= GAP;
                    end
                end
                GAP: begin
                    if (gap_count == '0) begin
                        state <= IDLE;
                    end else begin
                        gap_count <= gap_count - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_egress_frame_scheduler.sv
// tb/tb_egress_frame_scheduler.sv - directed scoreboard bench for egress_frame_scheduler
module tb_egress_frame_scheduler;

    logic       clock;
    logic       reset_n;
    logic [2:0] request;
    logic [2:0] request_enable;
    logic       frame_last;
    logic [2:0] grant;
    logic       grant_valid;
    logic [1:0] grant_index;
    logic       grant_timeout;

    int checks = 0;
    int fails  = 0;
    int exp_q[$];

    egress_frame_scheduler #(
        .NUMBER_OF_REQUESTERS  (3),
        .INTER_FRAME_GAP_CYCLES(96),
        .MAX_GRANT_CYCLES      (200)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .request       (request),
        .request_enable(request_enable),
        .frame_last    (frame_last),
        .grant         (grant),
        .grant_valid   (grant_valid),
        .grant_index   (grant_index),
        .grant_timeout (grant_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_grant(output int cycles);
        cycles = 0;
        while (!grant_valid && cycles < 400) begin
            step();
            cycles++;
        end
        check("wait_grant", {31'd0, grant_valid}, 32'd1);
    endtask

    task automatic frame_end();
        frame_last = 1'b1;
        step();
        frame_last = 1'b0;
        check("release_grant", {29'd0, grant}, 32'd0);
        check("release_valid", {31'd0, grant_valid}, 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("reset_grant", {29'd0, grant}, 32'd0);
        check("reset_valid", {31'd0, grant_valid}, 32'd0);
        check("reset_index", {30'd0, grant_index}, 32'd0);
        check("reset_timeout", {31'd0, grant_timeout}, 32'd0);
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic check_next_grant(input string tag, input int hold);
        int c;
        int e;
        logic [2:0] oh;
        wait_grant(c);
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e  = exp_q.pop_front();
            oh = 3'b001 << e;
            check({tag, "_index"}, {30'd0, grant_index}, 32'(e));
            check({tag, "_onehot"}, {29'd0, grant}, {29'd0, oh});
            repeat (hold) step();
            frame_end();
        end
    endtask

    initial begin
        int c;
        int wd;
        logic seen_timeout;

        reset_n        = 1'b0;
        request        = 3'b010;
        request_enable = 3'b111;
        frame_last     = 1'b0;

        // Single requester: latency, release, IFG spacing
        @(negedge clock);
        do_reset();
        step();
        check("single_grant", {29'd0, grant}, 32'h2);
        check("single_index", {30'd0, grant_index}, 32'd1);
        repeat (63) step();
        frame_end();
        check("index_kept", {30'd0, grant_index}, 32'd1);
        wait_grant(c);
        check("regrant_latency", 32'(c), 32'd97);
        frame_end();

        // Fairness across three continuous requesters
        request = 3'b111;
        do_reset();
        for (int i = 0; i < 6; i++) exp_q.push_back(i % 3);
        for (int i = 0; i < 6; i++) check_next_grant("fair", 10);

        // Masked requester 1 is never granted
        request_enable = 3'b101;
        do_reset();
        exp_q.push_back(0); exp_q.push_back(2); exp_q.push_back(0); exp_q.push_back(2);
        for (int i = 0; i < 4; i++) check_next_grant("mask", 5);
        request_enable = 3'b111;

        // Sticky grant survives request and enable dropping
        request = 3'b001;
        do_reset();
        wait_grant(c);
        check("sticky_first", {29'd0, grant}, 32'h1);
        request        = 3'b000;
        request_enable = 3'b000;
        repeat (20) step();
        check("sticky_grant", {29'd0, grant}, 32'h1);
        check("sticky_valid", {31'd0, grant_valid}, 32'd1);
        frame_end();
        request_enable = 3'b111;

        // Watchdog: no frame_last
        request = 3'b011;
        do_reset();
        wait_grant(c);
        check("wd_first_index", {30'd0, grant_index}, 32'd0);
`ifdef EGRESS_SCHEDULER_WATCHDOG_EN
        wd = 1;
        while (grant_valid && wd < 400) begin
            step();
            if (grant_valid) wd++;
        end
        check("wd_grant_cycles", 32'(wd), 32'd200);
        check("wd_timeout_pulse", {31'd0, grant_timeout}, 32'd1);
        check("wd_grant_cleared", {29'd0, grant}, 32'd0);
        step();
        check("wd_timeout_single", {31'd0, grant_timeout}, 32'd0);
`else
        wd = 0;
        seen_timeout = 1'b0;
        repeat (300) begin
            step();
            seen_timeout |= grant_timeout;
        end
        check("no_wd_held", {29'd0, grant}, 32'h1);
        check("no_wd_no_timeout", {31'd0, seen_timeout}, 32'd0);
        frame_end();
`endif
        exp_q.push_back(1);
        wait_grant(c);
        c = exp_q.pop_front();
        check("after_release_index", {30'd0, grant_index}, 32'(c));

        // Reset while requester 1 holds the grant; pointer must restart at 0
        request = 3'b111;
        do_reset();
        wait_grant(c);
        check("post_reset_index", {30'd0, grant_index}, 32'd0);
        check("post_reset_grant", {29'd0, grant}, 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
